// File: rtl/branch_pred_ctrl.sv
// Gshare prediction controller: forms the PHT index from PC ^ speculative GHR,
// tracks in-flight predictions in a FIFO and drives PHT updates at resolution.
module branch_pred_ctrl #(
    parameter int unsigned ENTRY  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_LSB = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic [31:0]              fetch_pc,
    output logic                     pred_ready,
    output logic [ENTRY-1:0]         read_index,
    input  logic [1:0]               pht_out,
    output logic                     pred_taken,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic [ENTRY-1:0]         write_index,
    input  logic [1:0]               current_state,
    output logic                     pht_load,
    output logic [1:0]               pht_in,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   inflight_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ENTRY-1:0] ghr_q, ghr_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [ENTRY-1:0] idx_q [DEPTH];
    logic [ENTRY-1:0] idx_d [DEPTH];
    logic             pred_q [DEPTH];
    logic             pred_d [DEPTH];
    logic [ENTRY-1:0] snap_q [DEPTH];
    logic [ENTRY-1:0] snap_d [DEPTH];

    logic accept, resolve, non_empty;

    always_comb begin
        read_index     = fetch_pc[PC_LSB +: ENTRY] ^ ghr_q;
        pred_taken     = pht_out[1];
        pred_ready     = (count_q != CW'(DEPTH));
        non_empty      = (count_q != '0);
        accept         = pred_valid & pred_ready & ~reset;
        resolve        = resolve_valid & non_empty & ~reset;
        write_index    = non_empty ? idx_q[head_q] : '0;
        pht_load       = resolve;
        mispredict     = resolve & (resolve_taken != pred_q[head_q]);
        inflight_count = count_q;
        pht_in         = 2'b00;
        if (resolve) begin
            if (resolve_taken) begin
                pht_in = (current_state == 2'b11) ? 2'b11 : current_state + 2'd1;
            end else begin
                pht_in = (current_state == 2'b00) ? 2'b00 : current_state - 2'd1;
            end
        end
    end

    always_comb begin
        ghr_d   = ghr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        idx_d   = idx_q;
        pred_d  = pred_q;
        snap_d  = snap_q;
        if (mispredict) begin
            // Flush drops any same-cycle push; history restarts from the head snapshot.
            ghr_d   = {snap_q[head_q][ENTRY-2:0], resolve_taken};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (accept) begin
                idx_d[tail_q]  = read_index;
                pred_d[tail_q] = pred_taken;
                snap_d[tail_q] = ghr_q;
                tail_d         = tail_q + PW'(1);
                ghr_d          = {ghr_q[ENTRY-2:0], pred_taken};
            end
            if (resolve) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(accept) - CW'(resolve);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ghr_q   <= ghr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        pred_q <= pred_d;
        snap_q <= snap_d;
    end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based gshare reference model.
module tb_branch_pred_ctrl;
    localparam int unsigned ENTRY  = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PC_LSB = 2;
    localparam int unsigned NPHT   = 1 << ENTRY;

    logic             clk;
    logic             reset;
    logic             pred_valid;
    logic [31:0]      fetch_pc;
    logic             pred_ready;
    logic [ENTRY-1:0] read_index;
    logic [1:0]       pht_out;
    logic             pred_taken;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [ENTRY-1:0] write_index;
    logic [1:0]       current_state;
    logic             pht_load;
    logic [1:0]       pht_in;
    logic             mispredict;
    logic [2:0]       inflight_count;

    branch_pred_ctrl #(.ENTRY(ENTRY), .DEPTH(DEPTH), .PC_LSB(PC_LSB)) dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .fetch_pc       (fetch_pc),
        .pred_ready     (pred_ready),
        .read_index     (read_index),
        .pht_out        (pht_out),
        .pred_taken     (pred_taken),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .write_index    (write_index),
        .current_state  (current_state),
        .pht_load       (pht_load),
        .pht_in         (pht_in),
        .mispredict     (mispredict),
        .inflight_count (inflight_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment PHT memory, written only by the DUT's write port.
    logic [1:0] pht_mem [NPHT];
    initial for (int i = 0; i < NPHT; i++) pht_mem[i] = 2'b11;
    always @(posedge clk) if (pht_load) pht_mem[write_index] <= pht_in;
    assign pht_out       = pht_mem[read_index];
    assign current_state = pht_mem[write_index];

    // Reference model: in-flight queue, history value and its own PHT image.
    typedef struct {
        int unsigned idx;
        bit          pred;
        int unsigned ghr;
    } ent_t;
    ent_t        mq[$];
    int unsigned mghr;
    int unsigned mpht [NPHT];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit pv, input logic [31:0] pc,
                        input bit rv, input bit rt);
        int unsigned e_idx, e_widx, cs, e_in, cnt;
        bit          e_pred, e_ready, acc, res, mis;
        @(negedge clk);
        reset         = rst;
        pred_valid    = pv;
        fetch_pc      = pc;
        resolve_valid = rv;
        resolve_taken = rt;
        #1;
        cnt     = mq.size();
        e_idx   = ((pc >> PC_LSB) % NPHT) ^ mghr;
        e_pred  = mpht[e_idx] >= 2;
        e_ready = cnt != DEPTH;
        acc     = pv && e_ready && !rst;
        res     = rv && cnt != 0 && !rst;
        e_widx  = (cnt != 0) ? mq[0].idx : 0;
        cs      = mpht[e_widx];
        e_in    = 0;
        if (res) e_in = rt ? ((cs == 3) ? 3 : cs + 1) : ((cs == 0) ? 0 : cs - 1);
        mis     = res && (rt != mq[0].pred);
        check_eq("read_index", 32'(read_index), e_idx);
        check_eq("pred_taken", 32'(pred_taken), 32'(e_pred));
        check_eq("pred_ready", 32'(pred_ready), 32'(e_ready));
        check_eq("inflight_count", 32'(inflight_count), cnt);
        check_eq("write_index", 32'(write_index), e_widx);
        check_eq("pht_load", 32'(pht_load), 32'(res));
        check_eq("pht_in", 32'(pht_in), e_in);
        check_eq("mispredict", 32'(mispredict), 32'(mis));
        if (res) mpht[e_widx] = e_in;
        if (rst) begin
            mq.delete();
            mghr = 0;
        end else if (mis) begin
            mghr = ((mq[0].ghr * 2) + (rt ? 1 : 0)) % NPHT;
            mq.delete();
        end else begin
            if (res) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{idx: e_idx, pred: e_pred, ghr: mghr});
                mghr = ((mghr * 2) + (e_pred ? 1 : 0)) % NPHT;
            end
        end
        @(posedge clk);
    endtask

    function automatic bit head_pred();
        return (mq.size() != 0) ? mq[0].pred : 1'b0;
    endfunction

    initial begin
        bit rt;
        for (int i = 0; i < NPHT; i++) mpht[i] = 3;
        mghr          = 0;
        reset         = 1'b1;
        pred_valid    = 1'b0;
        fetch_pc      = '0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, first prediction and saturating correct resolve.
        step(1, 0, 32'h0, 0, 0);
        step(0, 1, 32'h40, 0, 0);
        step(0, 0, 32'h40, 1, 1);
        step(0, 0, 32'h0, 0, 0);

        // Three taken predictions then a not-taken resolve of the head.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h40, 0, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 0);

        // Fill the FIFO, attempt a fifth push, drain to three, then stream through wrap.
        for (int i = 0; i < 5; i++) step(0, 1, 32'h100 + 32'(i * 4), 0, 0);
        step(0, 0, 32'h0, 1, head_pred());
        for (int i = 0; i < 10; i++) step(0, 1, 32'h200 + 32'(i * 8), 1, head_pred());
        while (mq.size() != 0) step(0, 0, 32'h0, 1, head_pred());

        // Accept colliding with a mispredict at count 2.
        for (int i = 0; i < 2; i++) step(0, 1, 32'h300 + 32'(i * 4), 0, 0);
        step(0, 1, 32'h380, 1, !head_pred());
        step(0, 0, 32'h0, 0, 0);

        // Resolve on empty FIFO; reset at count 2 with resolve pending.
        step(0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 2; i++) step(0, 1, 32'h400 + 32'(i * 4), 0, 0);
        step(1, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 0, 0);

        // Random traffic; outcomes mostly agree with the head so the FIFO stays busy.
        for (int n = 0; n < 3000; n++) begin
            rt = ($urandom_range(3) != 0) ? head_pred() : bit'($urandom_range(1));
            step(($urandom_range(63) == 0), bit'($urandom_range(1)), $urandom,
                 bit'($urandom_range(1)), rt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
